imem_boot_loader: RTL

- Upstream feeder of the pipelined CPU. It receives a program as a byte stream (valid/ready, from the UART RX block), packs it into 32-bit little-endian words and writes them into instruction memory through its write port.
- Holds the CPU in reset until a complete, checksum-verified image has been written, then releases it.
- Re-armable at run time by a `start` pulse, which puts the CPU back into reset and waits for a new image.

---
 rtl/imem_boot_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Receives a program image as a byte stream and writes it, packed as 32-bit
// little-endian words, into instruction memory. The CPU is held in reset
// until a complete image with a matching XOR checksum has been written.
//
// Frame: SYNC_BYTE, len[7:0], len[15:8], 4*len payload bytes, checksum.
//        len is in words; checksum = XOR of both length bytes and all payload.
//
// Handshake: a byte moves when in_valid && in_ready at a rising clk edge.
//            in_ready depends only on state (never on in_valid), is high
//            while loading and low in RUN/ERR; the sender may idle freely.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   in_data/in_valid/in_ready   byte stream input
//   start                 one-cycle pulse, re-arms from RUN or ERR
//   imem_we/addr/wdata    instruction-memory write port (one cycle per word)
//   cpu_rst               active-low CPU reset (1 only in RUN)
//   done, err             level status flags
//   dbg_state             current FSM state for observation

module imem_boot_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_RUN  = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    // Largest legal length in words (the full memory depth).
    localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

    state_t            state, next_state;
    logic [15:0]       len;
    logic [7:0]        csum;
    logic [1:0]        byte_idx;
    logic [23:0]       wbuf;      // lanes 0..2 of the word being assembled
    logic [ADDR_W:0]   word_cnt;  // one extra bit so len == depth does not wrap
    logic              beat;
    logic              last_word;
    logic [16:0]       full_len;  // length as seen while accepting len[15:8]

    logic in_ready_d, cpu_rst_d, done_d, err_d;

    assign beat      = in_valid && in_ready;
    assign full_len  = {1'b0, in_data, len[7:0]};
    assign last_word = (17'(word_cnt) + 17'd1) == {1'b0, len};
    assign dbg_state = state;

    // State register and datapath.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            cpu_rst    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            len        <= '0;
            csum       <= '0;
            byte_idx   <= '0;
            wbuf       <= '0;
            word_cnt   <= '0;
        end else begin
            state    <= next_state;
            in_ready <= in_ready_d;
            cpu_rst  <= cpu_rst_d;
            done     <= done_d;
            err      <= err_d;
            imem_we  <= 1'b0;
            if (beat) begin
                case (state)
                    S_IDLE: begin
                        if (in_data == SYNC_BYTE) csum <= '0;
                    end
                    S_LEN0: begin
                        len[7:0] <= in_data;
                        csum     <= csum ^ in_data;
                    end
                    S_LEN1: begin
                        len[15:8] <= in_data;
                        csum      <= csum ^ in_data;
                        word_cnt  <= '0;
                        byte_idx  <= '0;
                    end
                    S_DATA: begin
                        csum     <= csum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: wbuf[7:0]   <= in_data;
                            2'd1: wbuf[15:8]  <= in_data;
                            2'd2: wbuf[23:16] <= in_data;
                            default: begin
                                // 4th byte completes the word: write next cycle.
                                imem_we    <= 1'b1;
                                imem_addr  <= word_cnt[ADDR_W-1:0];
                                imem_wdata <= {in_data, wbuf};
                                word_cnt   <= word_cnt + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (beat && in_data == SYNC_BYTE) next_state = S_LEN0;
            S_LEN0: if (beat) next_state = S_LEN1;
            S_LEN1: begin
                if (beat) begin
                    if (full_len == 17'd0)      next_state = S_CSUM;
                    else if (full_len > MAX_LEN) next_state = S_ERR;
                    else                         next_state = S_DATA;
                end
            end
            S_DATA: if (beat && byte_idx == 2'd3 && last_word) next_state = S_CSUM;
            S_CSUM: if (beat) next_state = (in_data == csum) ? S_RUN : S_ERR;
            S_RUN:  if (start) next_state = S_IDLE;
            S_ERR:  if (start) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered flags change in
    // the same cycle the state does.
    always_comb begin
        in_ready_d = 1'b0;
        cpu_rst_d  = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (next_state)
            S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM: in_ready_d = 1'b1;
            S_RUN: begin
                cpu_rst_d = 1'b1;
                done_d    = 1'b1;
            end
            S_ERR: err_d = 1'b1;
            default: ;
        endcase
    end

endmodule
